// File: rtl/alu.sv
// Registered WIDTH-bit MIPS execute-stage ALU (AND, OR, ADD, SUB, SLT) built from a ripple chain
// of 1-bit slices; result, zero and overflow are captured together one cycle after sampling.
module alu #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  // One slice: returns {carry_out, sum, or, and}; b is inverted when binv is set.
  function automatic logic [3:0] alu_slice(input logic ai, input logic bi,
                                           input logic cin, input logic binv);
    logic bb;
    bb = bi ^ binv;
    return {(ai & bb) | (ai & cin) | (bb & cin), ai ^ bb ^ cin, ai | bi, ai & bi};
  endfunction

  logic [WIDTH:0]   carry_s;
  logic [WIDTH-1:0] and_s;
  logic [WIDTH-1:0] or_s;
  logic [WIDTH-1:0] sum_s;
  logic             ovf_s;
  logic             set_s;
  logic [WIDTH-1:0] next_result_s;
  logic             next_ovf_s;
  logic [WIDTH-1:0] result_r;
  logic             zero_r;
  logic             overflow_r;

  // Ripple chain; op[2] both inverts b and supplies the +1 for subtraction.
  always_comb begin
    logic [3:0] slice_s;
    carry_s    = {(WIDTH+1){1'b0}};
    and_s      = {WIDTH{1'b0}};
    or_s       = {WIDTH{1'b0}};
    sum_s      = {WIDTH{1'b0}};
    slice_s    = 4'b0000;
    carry_s[0] = op[2];
    for (int i = 0; i < WIDTH; i++) begin
      slice_s      = alu_slice(a[i], b[i], carry_s[i], op[2]);
      and_s[i]     = slice_s[0];
      or_s[i]      = slice_s[1];
      sum_s[i]     = slice_s[2];
      carry_s[i+1] = slice_s[3];
    end
  end

  assign ovf_s = carry_s[WIDTH] ^ carry_s[WIDTH-1];
  // Correcting the sign bit with overflow gives a true signed a < b.
  assign set_s = sum_s[WIDTH-1] ^ ovf_s;

  // Operation select; reserved codes yield zero result and no overflow.
  always_comb begin
    next_result_s = {WIDTH{1'b0}};
    next_ovf_s    = 1'b0;
    case (op)
      OP_AND: next_result_s = and_s;
      OP_OR:  next_result_s = or_s;
      OP_ADD: begin
        next_result_s = sum_s;
        next_ovf_s    = ovf_s;
      end
      OP_SUB: begin
        next_result_s = sum_s;
        next_ovf_s    = ovf_s;
      end
      OP_SLT: next_result_s = {{(WIDTH-1){1'b0}}, set_s};
      default: begin
        next_result_s = {WIDTH{1'b0}};
        next_ovf_s    = 1'b0;
      end
    endcase
  end

  // Output stage; zero is computed from the incoming result, never from the stored one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_r   <= {WIDTH{1'b0}};
      zero_r     <= 1'b1;
      overflow_r <= 1'b0;
    end else begin
      result_r   <= next_result_s;
      zero_r     <= (next_result_s == {WIDTH{1'b0}});
      overflow_r <= next_ovf_s;
    end
  end

  assign result   = result_r;
  assign zero     = zero_r;
  assign overflow = overflow_r;

endmodule

// File: tb/tb_alu.sv
// Table-driven self-checking bench for alu: back-to-back directed vectors plus reset sequences.
module tb_alu;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;

  int tests;
  int fails;

  typedef struct {
    string      name;
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] res;
    logic       z;
    logic       ovf;
  } vec_t;

  vec_t vecs[$];

  alu #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .op(op), .a(a), .b(b),
    .result(result), .zero(zero), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add_vec(input string name, input logic [2:0] o, input logic [3:0] va,
                         input logic [3:0] vb, input logic [3:0] r, input logic z,
                         input logic v);
    vec_t t;
    t.name = name; t.op = o; t.a = va; t.b = vb; t.res = r; t.z = z; t.ovf = v;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic check_outs(input string name, input logic [3:0] r, input logic z,
                            input logic v);
    check({name, ".result"}, result, r);
    check({name, ".zero"}, {3'b000, zero}, {3'b000, z});
    check({name, ".overflow"}, {3'b000, overflow}, {3'b000, v});
  endtask

  initial begin
    tests = 0;
    fails = 0;
    add_vec("and",          3'b000, 4'b0111, 4'b0001, 4'b0001, 1'b0, 1'b0);
    add_vec("or",           3'b001, 4'b0101, 4'b0010, 4'b0111, 1'b0, 1'b0);
    add_vec("add",          3'b010, 4'b0101, 4'b0001, 4'b0110, 1'b0, 1'b0);
    add_vec("add_ovf",      3'b010, 4'b0111, 4'b0001, 4'b1000, 1'b0, 1'b1);
    add_vec("sub",          3'b110, 4'b0101, 4'b0001, 4'b0100, 1'b0, 1'b0);
    add_vec("sub_wrap",     3'b110, 4'b1111, 4'b0001, 4'b1110, 1'b0, 1'b0);
    add_vec("sub_zero",     3'b110, 4'b0011, 4'b0011, 4'b0000, 1'b1, 1'b0);
    add_vec("rsvd101",      3'b101, 4'b1111, 4'b0001, 4'b0000, 1'b1, 1'b0);
    add_vec("slt_pos_ge",   3'b111, 4'b0101, 4'b0001, 4'b0000, 1'b1, 1'b0);
    add_vec("slt_neg_lt",   3'b111, 4'b1110, 4'b1111, 4'b0001, 1'b0, 1'b0);
    add_vec("slt_ovf_ge",   3'b111, 4'b0111, 4'b1000, 4'b0000, 1'b1, 1'b0);
    add_vec("slt_ovf_lt",   3'b111, 4'b1000, 4'b0111, 4'b0001, 1'b0, 1'b0);
    add_vec("sub_ovf",      3'b110, 4'b1000, 4'b0001, 4'b0111, 1'b0, 1'b1);
    add_vec("add_ovf_zero", 3'b010, 4'b1000, 4'b1000, 4'b0000, 1'b1, 1'b1);
    add_vec("and_zero",     3'b000, 4'b1010, 4'b0101, 4'b0000, 1'b1, 1'b0);
    add_vec("rsvd011",      3'b011, 4'b0111, 4'b0111, 4'b0000, 1'b1, 1'b0);
    add_vec("rsvd100",      3'b100, 4'b0110, 4'b0001, 4'b0000, 1'b1, 1'b0);
    add_vec("slt_eq",       3'b111, 4'b1001, 4'b1001, 4'b0000, 1'b1, 1'b0);

    // Power-on reset held across edges with live inputs.
    rst = 1'b1;
    op = 3'b010; a = 4'b0101; b = 4'b0001;
    #1;
    check_outs("por", 4'b0000, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_outs("por_hold", 4'b0000, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Vectors applied on consecutive edges, each checked just after its sampling edge.
    foreach (vecs[i]) begin
      op = vecs[i].op; a = vecs[i].a; b = vecs[i].b;
      @(posedge clk);
      #1;
      check_outs(vecs[i].name, vecs[i].res, vecs[i].z, vecs[i].ovf);
    end

    // Mid-stream reset: outputs clear without a clock and ignore edges while held.
    op = 3'b010; a = 4'b0111; b = 4'b0001;
    @(posedge clk);
    #1;
    check_outs("pre_rst", 4'b1000, 1'b0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_outs("async_rst", 4'b0000, 1'b1, 1'b0);
    op = 3'b001; a = 4'b0101; b = 4'b0010;
    repeat (2) @(posedge clk);
    #1;
    check_outs("rst_hold", 4'b0000, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_outs("rst_release", 4'b0000, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    check_outs("first_after_rst", 4'b0111, 1'b0, 1'b0);
    op = 3'b110; a = 4'b0011; b = 4'b0101;
    @(posedge clk);
    #1;
    check_outs("sub_neg", 4'b1110, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
